// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional macro ALU_ILLEGAL_OP_CHK_EN: opcodes 110/111 return 0 with resp_err set.
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [OP_W-1:0]   r0_req_op,
  input  logic [DATA_W-1:0] r0_req_a,
  input  logic [DATA_W-1:0] r0_req_b,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [OP_W-1:0]   r1_req_op,
  input  logic [DATA_W-1:0] r1_req_a,
  input  logic [DATA_W-1:0] r1_req_b,
  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  output logic [DATA_W-1:0] r0_resp_data,
  output logic              r0_resp_err,
  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [DATA_W-1:0] r1_resp_data,
  output logic              r1_resp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_illegal;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic [1:0]        r_resp_valid;
  logic [1:0]        r_resp_err;
  logic [DATA_W-1:0] r_resp_data [2];

  logic [1:0]        w_req_valid;
  logic [1:0]        w_req_ready;
  logic [1:0]        w_resp_ready;
  logic              w_grant;
  logic              w_accept;
  logic              w_resp_fire;
  logic              w_illegal;
  logic [OP_W-1:0]   w_sel_op;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;

  assign w_req_valid  = {r1_req_valid, r0_req_valid};
  assign w_resp_ready = {r1_resp_ready, r0_resp_ready};

  // Contested cycle goes to whoever was not granted last.
  always_comb begin
    w_grant = w_req_valid[1];
    if (w_req_valid == 2'b11) w_grant = ~r_last_grant;
  end

  assign w_accept    = (r_state == ST_IDLE) && (|w_req_valid);
  assign w_sel_op    = w_grant ? r1_req_op : r0_req_op;
  assign w_sel_a     = w_grant ? r1_req_a  : r0_req_a;
  assign w_sel_b     = w_grant ? r1_req_b  : r0_req_b;
  assign w_resp_fire = |(r_resp_valid & w_resp_ready);

`ifdef ALU_ILLEGAL_OP_CHK_EN
  assign w_illegal = (w_sel_op > OP_W'(5));
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_EXEC;
            r_last_grant <= w_grant;
            r_grant      <= w_grant;
            r_illegal    <= w_illegal;
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_op     <= w_illegal ? '0 : w_sel_op;
          end
        end
        ST_EXEC: r_state <= ST_RESP;
        ST_RESP: if (w_resp_fire) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-requester response registers keep each side's last result independently.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign w_req_ready[gi] = (r_state == ST_IDLE) && w_req_valid[gi] && (w_grant == 1'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_resp_valid[gi] <= 1'b0;
          r_resp_err[gi]   <= 1'b0;
          r_resp_data[gi]  <= '0;
        end else if ((r_state == ST_EXEC) && (r_grant == 1'(gi))) begin
          r_resp_valid[gi] <= 1'b1;
          r_resp_err[gi]   <= r_illegal;
          r_resp_data[gi]  <= r_illegal ? '0 : alu_result;
        end else if (r_resp_valid[gi] && w_resp_ready[gi]) begin
          r_resp_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign r0_req_ready  = w_req_ready[0];
  assign r1_req_ready  = w_req_ready[1];
  assign r0_resp_valid = r_resp_valid[0];
  assign r1_resp_valid = r_resp_valid[1];
  assign r0_resp_data  = r_resp_data[0];
  assign r1_resp_data  = r_resp_data[1];
  assign r0_resp_err   = r_resp_err[0];
  assign r1_resp_err   = r_resp_err[1];
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected responses plus per-scenario checks.
module tb_alu_arbiter;
  localparam int DW = 16;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req_valid, r1_req_valid, r0_req_ready, r1_req_ready;
  logic [OW-1:0] r0_req_op, r1_req_op;
  logic [DW-1:0] r0_req_a, r0_req_b, r1_req_a, r1_req_b;
  logic          r0_resp_valid, r1_resp_valid, r0_resp_ready, r1_resp_ready;
  logic [DW-1:0] r0_resp_data, r1_resp_data;
  logic          r0_resp_err, r1_resp_err;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_op;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic [1:0]    v_req_valid, v_req_ready, v_resp_valid, v_resp_ready, v_resp_err;
  logic [OW-1:0] v_req_op [2];
  logic [DW-1:0] v_req_a [2];
  logic [DW-1:0] v_req_b [2];
  logic [DW-1:0] v_resp_data [2];

  assign v_req_valid  = {r1_req_valid, r0_req_valid};
  assign v_req_ready  = {r1_req_ready, r0_req_ready};
  assign v_resp_valid = {r1_resp_valid, r0_resp_valid};
  assign v_resp_ready = {r1_resp_ready, r0_resp_ready};
  assign v_resp_err   = {r1_resp_err, r0_resp_err};
  assign v_req_op[0] = r0_req_op;
  assign v_req_op[1] = r1_req_op;
  assign v_req_a[0]  = r0_req_a;
  assign v_req_a[1]  = r1_req_a;
  assign v_req_b[0]  = r0_req_b;
  assign v_req_b[1]  = r1_req_b;
  assign v_resp_data[0] = r0_resp_data;
  assign v_resp_data[1] = r1_resp_data;

  always #5 clk = ~clk;

  // External shared ALU
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a << alu_b[3:0];
      3'd5:    alu_result = alu_a >> alu_b[3:0];
      default: alu_result = '0;
    endcase
  end

  alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_op(r0_req_op),
    .r0_req_a(r0_req_a), .r0_req_b(r0_req_b),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_op(r1_req_op),
    .r1_req_a(r1_req_a), .r1_req_b(r1_req_b),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r0_resp_data(r0_resp_data), .r0_resp_err(r0_resp_err),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .r1_resp_data(r1_resp_data), .r1_resp_err(r1_resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  function automatic exp_t model(input logic id, input logic [OW-1:0] op,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (op)
      3'd0:    e.data = a + b;
      3'd1:    e.data = a - b;
      3'd2:    e.data = a & b;
      3'd3:    e.data = a | b;
      3'd4:    e.data = a << b[3:0];
      3'd5:    e.data = a >> b[3:0];
      default: e.data = '0;
    endcase
`ifdef ALU_ILLEGAL_OP_CHK_EN
    if (op > 3'd5) begin
      e.data = '0;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Advance one clock; record accepts into the scoreboard and match completed responses.
  task automatic cycle();
    exp_t e;
    #1;
    for (int i = 0; i < 2; i++)
      if (v_req_valid[i] && v_req_ready[i])
        sb_q.push_back(model(i[0], v_req_op[i], v_req_a[i], v_req_b[i]));
    for (int i = 0; i < 2; i++) begin
      if (v_resp_valid[i] && v_resp_ready[i]) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_resp r%0d: got unexpected response data=%h, required none", i, v_resp_data[i]);
        end else begin
          e = sb_q.pop_front();
          if ({i[0], v_resp_data[i], v_resp_err[i]} !== e) begin
            fails++;
            $display("FAIL sb_resp r%0d: got data=%h err=%b, required r%0d data=%h err=%b",
                     i, v_resp_data[i], v_resp_err[i], e.id, e.data, e.err);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int id, input logic v, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (id == 0) begin
      r0_req_valid = v; r0_req_op = op; r0_req_a = a; r0_req_b = b;
    end else begin
      r1_req_valid = v; r1_req_op = op; r1_req_a = a; r1_req_b = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    r0_resp_ready = 1'b0;
    r1_resp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    r0_resp_ready = 1'b0;
    r1_resp_ready = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid, r0_resp_err, r1_resp_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 000000",
               {r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid, r0_resp_err, r1_resp_err});
    end
    tests++;
    if ({alu_a, alu_b, alu_op, r0_resp_data, r1_resp_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: got a=%h b=%h op=%h d0=%h d1=%h, required all 0",
               alu_a, alu_b, alu_op, r0_resp_data, r1_resp_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_single();
    do_reset();
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 16'h0005, 16'h0003);
    #1;
    tests++;
    if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL add_ready: got r0=%b r1=%b, required r0=1 r1=0", r0_req_ready, r1_req_ready);
    end
    cycle();
    set_req(0, 1'b0, '0, '0, '0);
    tests++;
    if (r0_resp_valid !== 1'b0 || alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_op !== 3'd0) begin
      fails++;
      $display("FAIL add_exec: got valid=%b a=%h b=%h op=%h, required valid=0 a=0005 b=0003 op=0",
               r0_resp_valid, alu_a, alu_b, alu_op);
    end
    cycle();
    tests++;
    if (r0_resp_valid !== 1'b1 || r0_resp_data !== 16'h0008) begin
      fails++;
      $display("FAIL add_latency: got valid=%b data=%h, required valid=1 data=0008", r0_resp_valid, r0_resp_data);
    end
    tests++;
    if (r1_resp_valid !== 1'b0 || r1_resp_data !== 16'h0000) begin
      fails++;
      $display("FAIL add_r1_untouched: got valid=%b data=%h, required 0 0000", r1_resp_valid, r1_resp_data);
    end
    cycle();
    tests++;
    if (r0_resp_valid !== 1'b0 || r0_resp_data !== 16'h0008) begin
      fails++;
      $display("FAIL add_hold: got valid=%b data=%h, required valid=0 data=0008", r0_resp_valid, r0_resp_data);
    end
  endtask

  task automatic test_round_robin();
    int   grants[$];
    int   tacc[$];
    logic both_seen;
    logic gap_ok;
    do_reset();
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 16'h0002, 16'h0003);
    set_req(1, 1'b1, 3'd1, 16'h0010, 16'h0001);
    both_seen = 1'b0;
    #1;
    for (int k = 0; k < 30 && grants.size() < 4; k++) begin
      if (r0_req_ready && r1_req_ready) both_seen = 1'b1;
      if (r0_req_ready) begin grants.push_back(0); tacc.push_back(cyc); end
      if (r1_req_ready) begin grants.push_back(1); tacc.push_back(cyc); end
      cycle();
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    tests++;
    if (grants.size() != 4 || both_seen) begin
      fails++;
      $display("FAIL rr_count: got %0d grants (double=%b), required 4 single grants", grants.size(), both_seen);
    end else begin
      tests++;
      if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
        fails++;
        $display("FAIL rr_order: got %0d %0d %0d %0d, required 0 1 0 1",
                 grants[0], grants[1], grants[2], grants[3]);
      end
      gap_ok = 1'b1;
      for (int k = 1; k < 4; k++) if (tacc[k] - tacc[k-1] != 3) gap_ok = 1'b0;
      tests++;
      if (!gap_ok) begin
        fails++;
        $display("FAIL rr_throughput: got accept cycles %0d %0d %0d %0d, required spacing 3",
                 tacc[0], tacc[1], tacc[2], tacc[3]);
      end
    end
    repeat (4) cycle();
    tests++;
    if (r1_resp_data !== 16'h000F) begin
      fails++;
      $display("FAIL rr_sub_result: got %h, required 000f", r1_resp_data);
    end
  endtask

  task automatic test_backpressure();
    logic bp_ok;
    do_reset();
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b0;
    set_req(1, 1'b1, 3'd3, 16'h00F0, 16'h000F);
    #1;
    tests++;
    if (r1_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_accept: got r1_req_ready=%b, required 1", r1_req_ready);
    end
    cycle();
    set_req(1, 1'b0, '0, '0, '0);
    set_req(0, 1'b1, 3'd0, 16'h0001, 16'h0001);
    cycle();
    bp_ok = 1'b1;
    repeat (5) begin
      if (r1_resp_valid !== 1'b1 || r1_resp_data !== 16'h00FF || r0_req_ready !== 1'b0 || r0_resp_valid !== 1'b0)
        bp_ok = 1'b0;
      cycle();
    end
    tests++;
    if (!bp_ok) begin
      fails++;
      $display("FAIL bp_hold: got valid=%b data=%h r0_ready=%b, required 1 00ff 0",
               r1_resp_valid, r1_resp_data, r0_req_ready);
    end
    r1_resp_ready = 1'b1;
    cycle();
    tests++;
    if (r0_req_ready !== 1'b1 || r1_resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: got r0_ready=%b r1_valid=%b, required 1 0", r0_req_ready, r1_resp_valid);
    end
    cycle();
    set_req(0, 1'b0, '0, '0, '0);
    repeat (3) cycle();
  endtask

  task automatic test_reset_in_exec();
    logic no_resp;
    do_reset();
    r0_resp_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 16'h0007, 16'h0008);
    #1;
    cycle();
    set_req(0, 1'b0, '0, '0, '0);
    tests++;
    if (alu_a !== 16'h0007) begin
      fails++;
      $display("FAIL rst_pre_exec: got alu_a=%h, required 0007", alu_a);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({alu_a, alu_b, alu_op, r0_resp_data, r0_resp_valid, r0_resp_err} !== '0) begin
      fails++;
      $display("FAIL rst_async_clear: got a=%h b=%h op=%h d0=%h v0=%b, required all 0",
               alu_a, alu_b, alu_op, r0_resp_data, r0_resp_valid);
    end
    #2;
    rst = 1'b0;
    sb_q.delete();
    no_resp = 1'b1;
    repeat (5) begin
      if (r0_resp_valid || r1_resp_valid) no_resp = 1'b0;
      cycle();
    end
    tests++;
    if (!no_resp) begin
      fails++;
      $display("FAIL rst_no_replay: got resp_valid after reset, required none");
    end
    set_req(0, 1'b1, 3'd0, '0, '0);
    set_req(1, 1'b1, 3'd0, '0, '0);
    #1;
    tests++;
    if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL rst_idle_grant: got r0=%b r1=%b, required r0=1 r1=0", r0_req_ready, r1_req_ready);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_illegal_op();
    logic [OW-1:0] exp_op;
    logic          exp_err;
`ifdef ALU_ILLEGAL_OP_CHK_EN
    exp_op  = 3'd0;
    exp_err = 1'b1;
`else
    exp_op  = 3'd7;
    exp_err = 1'b0;
`endif
    do_reset();
    r0_resp_ready = 1'b1;
    set_req(0, 1'b1, 3'd7, 16'h1234, 16'h0001);
    #1;
    cycle();
    set_req(0, 1'b0, '0, '0, '0);
    tests++;
    if (alu_op !== exp_op || alu_a !== 16'h1234) begin
      fails++;
      $display("FAIL ill_alu_op: got op=%h a=%h, required op=%h a=1234", alu_op, alu_a, exp_op);
    end
    cycle();
    tests++;
    if (r0_resp_valid !== 1'b1 || r0_resp_err !== exp_err || r0_resp_data !== 16'h0000) begin
      fails++;
      $display("FAIL ill_resp: got valid=%b err=%b data=%h, required 1 %b 0000",
               r0_resp_valid, r0_resp_err, r0_resp_data, exp_err);
    end
    cycle();
  endtask

  task automatic test_ops();
    logic [OW-1:0] t_op  [4] = '{3'd2, 3'd4, 3'd5, 3'd1};
    logic [DW-1:0] t_a   [4] = '{16'hF0F0, 16'h0001, 16'h8000, 16'h0000};
    logic [DW-1:0] t_b   [4] = '{16'h0FF0, 16'h0004, 16'h000F, 16'h0001};
    logic [DW-1:0] t_exp [4] = '{16'h00F0, 16'h0010, 16'h0001, 16'hFFFF};
    logic          hit;
    do_reset();
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(t % 2, 1'b1, t_op[t], t_a[t], t_b[t]);
      #1;
      hit = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
        hit = v_req_ready[t % 2];
        cycle();
      end
      set_req(t % 2, 1'b0, '0, '0, '0);
      for (int k = 0; k < 10 && hit && !v_resp_valid[t % 2]; k++) cycle();
      tests++;
      if (!hit || v_resp_valid[t % 2] !== 1'b1 || v_resp_data[t % 2] !== t_exp[t]) begin
        fails++;
        $display("FAIL ops_%0d: got accepted=%b valid=%b data=%h, required 1 1 %h",
                 t, hit, v_resp_valid[t % 2], v_resp_data[t % 2], t_exp[t]);
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    test_illegal_op();
    test_ops();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drained: got %0d pending responses, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter OP_W, default 3, ALU opcode width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports r0_req_valid/r1_req_valid  input  1  requester n has an operation.
REQ-006 SHALL have ports r0_req_ready/r1_req_ready  output  1  arbiter accepts requester n this cycle.
REQ-007 SHALL have ports r0_req_op/r1_req_op  input  OP_W  opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR).
REQ-008 SHALL have ports r0_req_a, r0_req_b, r1_req_a, r1_req_b  input  DATA_W  operands.
REQ-009 SHALL have ports r0_resp_valid/r1_resp_valid  output  1  result ready for requester n.
REQ-010 SHALL have ports r0_resp_ready/r1_resp_ready  input  1  requester n takes result.
REQ-011 SHALL have ports r0_resp_data/r1_resp_data  output  DATA_W  result.
REQ-012 SHALL have ports r0_resp_err/r1_resp_err  output  1  illegal opcode flag.
REQ-013 SHALL have ports alu_a, alu_b  output  DATA_W  and alu_op  output  OP_W  driving the shared combinational ALU.
REQ-014 SHALL have port alu_result  input  DATA_W  from the shared ALU.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one transaction in flight.
REQ-016 SHALL in IDLE assert reqN_ready combinationally for exactly the granted requester only; none when neither valid.
REQ-017 SHALL arbitrate round-robin: one valid -> it wins; both valid -> requester not granted last wins.
REQ-018 SHALL update last_grant register only on accept (valid && ready); IDLE -> EXEC on accept.
REQ-019 SHALL on accept register op, a, b into alu_op/alu_a/alu_b; these outputs hold until next accept.
REQ-020 SHALL in EXEC capture alu_result into a result register at cycle end, then go to RESP.
REQ-021 SHALL in RESP assert respN_valid for the granted requester only, data and err stable until respN_ready.
REQ-022 SHALL leave RESP to IDLE on respN_valid && respN_ready; new accept possible the following cycle.
REQ-023 SHALL give latency: accept at cycle N -> resp_valid high from cycle N+2; back-to-back throughput one op per 3 cycles with resp_ready tied high.
REQ-024 SHALL ignore req_valid changes and the non-granted resp_ready outside their handshake windows.
REQ-025 SHALL hold respN_data at last value when respN_valid low (no clearing).

Reset
REQ-026 SHALL on rst go to IDLE immediately, in-flight transaction discarded, not replayed.
REQ-027 SHALL reset alu_a, alu_b, alu_op, resp_data, resp_err, resp_valid to 0.
REQ-028 SHALL reset last_grant to requester 1 so requester 0 wins the first contested cycle.

Configuration
REQ-029 SHALL use macro ALU_ILLEGAL_OP_CHK_EN.
REQ-030 SHALL with macro defined: opcode 110/111 accepted, alu_op driven 000, result 0, resp_err 1, same latency.
REQ-031 SHALL without macro: opcode forwarded unchanged, resp_err tied 0.

Verification
REQ-032 SHALL cover: r0 ADD a=0x0005 b=0x0003, resp_ready=1 -> r0_resp_valid at N+2, data 0x0008, r1 untouched.
REQ-033 SHALL cover: r0 and r1 valid together from reset, both persistent -> grants r0, r1, r0, r1; r1 SUB 0x0010-0x0001 returns 0x000F.
REQ-034 SHALL cover: r1 OR 0x00F0|0x000F with r1_resp_ready low 5 cycles -> resp_valid and 0x00FF held stable, no new accept until released.
REQ-035 SHALL cover: rst pulsed in EXEC -> all outputs 0, state IDLE, no resp_valid afterwards for that transaction.
REQ-036 SHALL cover: opcode 111 a=0x1234 -> with macro data 0x0000 err 1 alu_op 000; without macro alu_op 111, err 0.
